// File: rtl/guess_checker.sv
// Game-round controller: generates a 4-digit BCD target, shows it for a level-scaled window,
// judges the decoder's guess and tracks score/level/lives. Optional guess timeout: GUESS_TIMEOUT_EN.
`timescale 1ns/1ps
module guess_checker #(
  parameter int unsigned SHOW_CYCLES = 100000000,
  parameter int unsigned LIVES_INIT  = 3,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int unsigned WAIT_CYCLES = 500000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        ready,
  input  logic [15:0] userInt,
  output logic [15:0] target,
  output logic        show_target,
  output logic        result_valid,
  output logic        match,
  output logic        timed_out,
  output logic [7:0]  score,
  output logic [1:0]  level,
  output logic [1:0]  lives,
  output logic        game_over
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_SHOW,
    S_WAIT,
    S_RESULT,
    S_OVER
  } state_t;

  localparam logic [1:0]  LIVES_RST = 2'(LIVES_INIT);
  localparam logic [31:0] WAIT_LOAD = 32'(WAIT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [15:0] lfsr;
  logic [1:0]  gen_idx;
  logic [31:0] cnt;
  logic [31:0] show_load;
  logic        timeout_evt;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [3:0] to_digit(input logic [3:0] d);
    return (d > 4'd9) ? (d - 4'd6) : d;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? v : (v + 2'd1);
  endfunction

  // Display window halves with every level gained.
  assign show_load = (32'(SHOW_CYCLES) >> level) - 32'd1;

`ifdef GUESS_TIMEOUT_EN
  assign timeout_evt = (state == S_WAIT) && !ready && (cnt == 32'd0);
`else
  assign timeout_evt = 1'b0;
`endif

  assign show_target  = (state == S_SHOW);
  assign result_valid = (state == S_RESULT);
  assign game_over    = (state == S_OVER);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_GEN;
      S_GEN:    if (gen_idx == 2'd3) state_nxt = S_SHOW;
      S_SHOW:   if (cnt == 32'd0) state_nxt = S_WAIT;
      S_WAIT:   if (ready || timeout_evt) state_nxt = S_RESULT;
      S_RESULT: state_nxt = (!match && (lives == 2'd1)) ? S_OVER : S_GEN;
      S_OVER:   if (start) state_nxt = S_GEN;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // The LFSR runs in every state so player timing perturbs the next target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr      <= SEED;
      gen_idx   <= 2'd0;
      cnt       <= 32'd0;
      target    <= 16'h0000;
      match     <= 1'b0;
      timed_out <= 1'b0;
      score     <= 8'd0;
      level     <= 2'd0;
      lives     <= 2'd0;
    end else begin
      lfsr <= lfsr_step(lfsr);
      case (state)
        S_IDLE, S_OVER: begin
          if (start) begin
            score     <= 8'd0;
            level     <= 2'd0;
            lives     <= LIVES_RST;
            match     <= 1'b0;
            timed_out <= 1'b0;
            gen_idx   <= 2'd0;
          end
        end
        S_GEN: begin
          target[{gen_idx, 2'b00} +: 4] <= to_digit(lfsr[3:0]);
          gen_idx <= gen_idx + 2'd1;
          if (gen_idx == 2'd3) cnt <= show_load;
        end
        S_SHOW: begin
          if (cnt == 32'd0) cnt <= WAIT_LOAD;
          else              cnt <= cnt - 32'd1;
        end
        S_WAIT: begin
          if (ready) begin
            match     <= (userInt == target);
            timed_out <= 1'b0;
          end else if (timeout_evt) begin
            match     <= 1'b0;
            timed_out <= 1'b1;
          end else if (cnt != 32'd0) begin
            cnt <= cnt - 32'd1;
          end
        end
        S_RESULT: begin
          gen_idx <= 2'd0;
          if (match) begin
            score <= sat_inc8(score);
            level <= sat_inc2(level);
          end else begin
            lives <= lives - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_guess_checker.sv
// Self-checking bench for guess_checker: randomized rounds against a plain game-rule model.
`timescale 1ns/1ps
module tb_guess_checker;

  localparam int          SHOW_CYCLES = 8;
  localparam int          LIVES_INIT  = 3;
  localparam int          WAIT_CYCLES = 16;
  localparam logic [15:0] SEED        = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ready = 1'b0;
  logic [15:0] userInt = 16'h0000;
  logic [15:0] target;
  logic        show_target, result_valid, match, timed_out, game_over;
  logic [7:0]  score;
  logic [1:0]  level, lives;

  guess_checker #(
    .SHOW_CYCLES(SHOW_CYCLES),
    .LIVES_INIT (LIVES_INIT),
    .SEED       (SEED),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .ready       (ready),
    .userInt     (userInt),
    .target      (target),
    .show_target (show_target),
    .result_valid(result_valid),
    .match       (match),
    .timed_out   (timed_out),
    .score       (score),
    .level       (level),
    .lives       (lives),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int exp_score = 0;
  int exp_level = 0;
  int exp_lives = 0;

  // Free-running random source as the game rules describe it; history of values seen at each edge.
  logic [15:0] m_lfsr = SEED;
  logic [15:0] hist[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lfsr = SEED;
      hist.delete();
    end else begin
      hist.push_back(m_lfsr);
      if (hist.size() > 8) void'(hist.pop_front());
      m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  function automatic logic [3:0] dig(input logic [3:0] d);
    return (d > 4'd9) ? (d - 4'd6) : d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_show();
    int n;
    n = 0;
    while (!show_target && n < 50) begin
      ready   = ($urandom_range(0, 3) == 0);
      userInt = 16'($urandom);
      @(negedge clk);
      n++;
    end
    ready = 1'b0;
    chk("show_rise", 32'(show_target), 32'd1);
  endtask

  task automatic play_round(input bit correct, input int idle, input bit early);
    int n;
    logic [15:0] tgt, et;
    wait_show();
    et = {dig(hist[$][3:0]), dig(hist[$-1][3:0]), dig(hist[$-2][3:0]), dig(hist[$-3][3:0])};
    chk("target", 32'(target), 32'(et));
    for (int i = 0; i < 4; i++) chk("digit_le9", 32'(target[i*4 +: 4] <= 4'd9), 32'd1);
    tgt = target;
    n = 0;
    while (show_target && n < 100) begin
      ready   = early && ($urandom_range(0, 2) == 0);
      userInt = tgt;
      @(negedge clk);
      n++;
    end
    ready = 1'b0;
    chk("show_len", 32'(n), 32'(SHOW_CYCLES >> exp_level));
    chk("no_early_result", 32'(result_valid), 32'd0);
    repeat (idle) @(negedge clk);
    chk("target_held", 32'(target), 32'(tgt));
    ready   = 1'b1;
    userInt = correct ? tgt : (tgt ^ 16'h0001);
    @(negedge clk);
    ready = 1'b0;
    chk("result_valid", 32'(result_valid), 32'd1);
    chk("match", 32'(match), 32'(correct));
    chk("timed_out", 32'(timed_out), 32'd0);
    if (correct) begin
      exp_score = (exp_score < 255) ? exp_score + 1 : 255;
      exp_level = (exp_level < 3) ? exp_level + 1 : 3;
    end else begin
      exp_lives = exp_lives - 1;
    end
    @(negedge clk);
    chk("result_pulse", 32'(result_valid), 32'd0);
    chk("score", 32'(score), 32'(exp_score));
    chk("level", 32'(level), 32'(exp_level));
    chk("lives", 32'(lives), 32'(exp_lives));
    chk("game_over", 32'(game_over), 32'(exp_lives == 0));
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_score = 0;
    exp_level = 0;
    exp_lives = LIVES_INIT;
    chk("start_lives", 32'(lives), 32'(LIVES_INIT));
    chk("start_score", 32'(score), 32'd0);
    chk("start_level", 32'(level), 32'd0);
    chk("start_game_over", 32'(game_over), 32'd0);
    chk("start_match", 32'(match), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit c;
    repeat (3) @(negedge clk);
    chk("rst_target", 32'(target), 32'd0);
    chk("rst_show", 32'(show_target), 32'd0);
    chk("rst_rv", 32'(result_valid), 32'd0);
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_to", 32'(timed_out), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_lives", 32'(lives), 32'd0);
    chk("rst_over", 32'(game_over), 32'd0);
    rst = 1'b0;
    repeat ($urandom_range(1, 7)) @(negedge clk);

    // Start: one IDLE cycle plus four GEN cycles before the target is shown.
    start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
    end while (!show_target && n < 50);
    chk("show_entry_latency", 32'(n), 32'd5);
    exp_lives = LIVES_INIT;
    chk("first_lives", 32'(lives), 32'(LIVES_INIT));

    play_round(1'b1, 0, 1'b0);
    play_round(1'b1, 2, 1'b1);
    for (int i = 0; i < 3; i++) play_round(1'b0, $urandom_range(0, 4), 1'b1);
    chk("over_score_kept", 32'(score), 32'd2);
    repeat (3) @(negedge clk);
    chk("over_hold", 32'(game_over), 32'd1);
    do_start();

`ifdef GUESS_TIMEOUT_EN
    wait_show();
    n = 0;
    while (show_target && n < 100) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!result_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_wait_len", 32'(n), 32'(WAIT_CYCLES));
    chk("timeout_flag", 32'(timed_out), 32'd1);
    chk("timeout_match", 32'(match), 32'd0);
    exp_lives = exp_lives - 1;
    @(negedge clk);
    chk("timeout_lives", 32'(lives), 32'(exp_lives));
`endif

    for (int r = 0; r < 20; r++) begin
      c = (exp_lives == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
      play_round(c, $urandom_range(0, 5), 1'b1);
    end

    for (int r = 0; r < 300; r++) play_round(1'b1, $urandom_range(0, 2), 1'b0);
    chk("score_saturated", 32'(score), 32'd255);
    chk("level_saturated", 32'(level), 32'd3);

    // Asynchronous reset in the middle of WAIT.
    wait_show();
    n = 0;
    while (show_target && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_target", 32'(target), 32'd0);
    chk("arst_show", 32'(show_target), 32'd0);
    chk("arst_rv", 32'(result_valid), 32'd0);
    chk("arst_match", 32'(match), 32'd0);
    chk("arst_to", 32'(timed_out), 32'd0);
    chk("arst_score", 32'(score), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_lives", 32'(lives), 32'd0);
    chk("arst_over", 32'(game_over), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ready = 1'b1;
    userInt = 16'h1234;
    repeat (2) @(negedge clk);
    ready = 1'b0;
    chk("idle_after_rst_rv", 32'(result_valid), 32'd0);
    chk("idle_after_rst_show", 32'(show_target), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/guess_checker.md
Name: guess_checker

Overview:
- Game-round controller directly downstream of the PS/2 keypad decoder.
- Generates a 4-digit decimal target and exposes it for a fixed display window, then hides it.
- Consumes the decoder's one-cycle `ready` pulse and 16-bit `userInt` guess, compares the guess to the target, and maintains score, lives and game-over status.
- Feeds the seven-segment/LED display logic.

Parameters:
- SHOW_CYCLES, 100000000, base target display window in clk cycles, level 0.
- LIVES_INIT, 3, lives at game start; range 1..3.
- SEED, 16'hACE1, LFSR reset value; must be nonzero.
- WAIT_CYCLES, 500000000, guess timeout in clk cycles; used only with GUESS_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  level; sampled in IDLE/OVER to begin a game
- ready  in  1  one-cycle pulse from decoder; guess valid
- userInt  in  16  guess; nibble 0 [3:0] is the first digit typed, nibble 3 [15:12] the last
- target  out  16  current target; same nibble order; BCD digits 0..9
- show_target  out  1  high while the display may show target
- result_valid  out  1  one-cycle pulse when a guess is judged
- match  out  1  result of last judgement; held until next judgement
- timed_out  out  1  last judgement was a timeout; held until next judgement
- score  out  8  rounds won; saturates at 255
- level  out  2  difficulty level; saturates at 3
- lives  out  2  remaining lives
- game_over  out  1  high in OVER

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; lfsr=SEED.
  - target=0, show_target=0, result_valid=0, match=0, timed_out=0.
  - score=0, level=0, lives=0, game_over=0.
- LFSR:
  - 16-bit Galois, mask 16'hB400, right shift.
  - Steps every clk cycle in every state, so user timing perturbs targets.
- Digit derivation: d = lfsr[3:0]; digit = (d>9) ? d-6 : d.
- IDLE:
  - On start=1: score=0, level=0, lives=LIVES_INIT, match=0, timed_out=0.
  - Next state GEN.
- GEN: 4 cycles; cycle k (0..3) loads target[4k+3:4k] from the current LFSR. Then SHOW.
- SHOW:
  - show_target=1; counter loads (SHOW_CYCLES>>level)-1 on entry and counts down.
  - At 0: show_target=0, go WAIT.
  - Window is exactly SHOW_CYCLES>>level cycles.
- WAIT:
  - On ready=1, latch match = (userInt==target); next RESULT.
- RESULT: one cycle with result_valid=1.
  - On match: score+1 (saturating); level+1 (saturating at 3).
  - On mismatch: lives-1.
  - Next state: if mismatch and lives was 1 → OVER (lives=0). Otherwise → GEN.
- OVER:
  - game_over=1; score/level/match held.
  - start=1 → re-initialise as in IDLE, then GEN.
- Ignored events:
  - ready outside WAIT is ignored, including during SHOW; an early-typed guess is dropped.
  - start outside IDLE/OVER is ignored.
- ready and state entry into WAIT in the same cycle: not judged; the guess must arrive after SHOW ends.
- Async reset mid-round: returns to IDLE immediately with all outputs at reset values; any partial guess is discarded.
- target remains valid (not cleared) after SHOW so the display can reveal it on a miss.

Optional Feature:
- Macro GUESS_TIMEOUT_EN.
- Defined:
  - WAIT loads a counter to WAIT_CYCLES-1 on entry.
  - Reaching 0 without ready forces match=0, timed_out=1 and enters RESULT, counting as a mismatch.
  - ready on the same cycle as expiry wins: it is judged normally, timed_out=0.
- Undefined: WAIT waits indefinitely; timed_out is tied 0; WAIT_CYCLES is unused.

Test Plan:
- Reset then start, SHOW_CYCLES=8, LIVES_INIT=3:
  - Entering SHOW takes exactly 1+4 cycles.
  - show_target is high for exactly 8 cycles.
  - Every target nibble is ≤9.
- Correct guess: in WAIT drive ready with userInt=target →
  - result_valid pulses once, match=1.
  - score 0→1, level 0→1, lives=3.
  - Next SHOW lasts 4 cycles.
- Three wrong guesses (userInt=target^16'h0001): lives 3→2→1→0, game_over=1 after the third RESULT; score unchanged. Then start=1 → lives=3, score=0, game_over=0.
- ready pulses during GEN and SHOW are ignored (no result_valid). A guess after SHOW is judged normally.
- Win 300 rounds: score saturates at 255, level saturates at 3, SHOW lasts 1 cycle with SHOW_CYCLES=8.
- GUESS_TIMEOUT_EN with WAIT_CYCLES=16, no ready → after 16 WAIT cycles result_valid=1, timed_out=1, match=0, lives-1. Assert rst mid-WAIT → all outputs reset asynchronously.
